ext_bus_sequencer: RTL and testbench

Sequences one 6502 core memory access (16-bit address, read or write) over the chip's 8-bit pin budget. It sits directly downstream of the core datapath and replaces the ad-hoc high/low address multiplexing in the top level. It drives the address high byte, then the address low byte, on the dedicated outputs, then runs a data phase on the bidirectional IOs. The data phase supports external wait-state insertion and a timeout abort. The core sees a simple req/done handshake, and the top wires the pin_* ports to uo_out/uio_*.

---
 rtl/ext_bus_sequencer_if.sv | 27 ++
 rtl/ext_bus_sequencer.sv | 99 +++++++++
 tb/tb_ext_bus_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ext_bus_sequencer_if.sv
// ext_bus_sequencer_if: core req/done handshake plus external pin bus for one sequenced 6502 access.
// Core side: req, addr, we, wdata in; busy, done, err, rdata out.
// Pin side: pin_addr, pin_phase, pin_data_out, pin_data_oe out; pin_data_in, wait_n in.
interface ext_bus_sequencer_if;
  logic        req;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rdata;
  logic [7:0]  pin_addr;
  logic [1:0]  pin_phase;
  logic [7:0]  pin_data_out;
  logic [7:0]  pin_data_oe;
  logic [7:0]  pin_data_in;
  logic        wait_n;
  modport master (
    output req, addr, we, wdata, pin_data_in, wait_n,
    input  busy, done, err, rdata, pin_addr, pin_phase, pin_data_out, pin_data_oe
  );
  modport slave (
    input  req, addr, we, wdata, pin_data_in, wait_n,
    output busy, done, err, rdata, pin_addr, pin_phase, pin_data_out, pin_data_oe
  );
endinterface

// File: rtl/ext_bus_sequencer.sv
// ext_bus_sequencer: drives addr-hi, addr-lo, then a wait-stretchable data phase for one core access.
// Ports: clk_output (clock), rst_n (sync active-low reset), bus (ext_bus_sequencer_if.slave).
module ext_bus_sequencer #(
  parameter int MAX_WAIT = 15
) (
  input logic clk_output,
  input logic rst_n,
  ext_bus_sequencer_if.slave bus
);
  // Encoding doubles as the pin_phase value.
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR_HI = 2'd1, ADDR_LO = 2'd2, DATA = 2'd3} state_t;
  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  pin_addr_q, pin_addr_d;
  logic [1:0]  pin_phase_q, pin_phase_d;
  logic [7:0]  pin_data_out_q, pin_data_out_d;
  logic [7:0]  pin_data_oe_q, pin_data_oe_d;
  logic        drive;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.req) begin
        state_d = ADDR_HI;
        addr_d  = bus.addr;
        we_d    = bus.we;
        wdata_d = bus.wdata;
        cnt_d   = 8'd0;
      end
      ADDR_HI: state_d = ADDR_LO;
      ADDR_LO: state_d = DATA;
      DATA: if (bus.wait_n) begin
        state_d = IDLE;
        done_d  = 1'b1;
        rdata_d = we_q ? rdata_q : bus.pin_data_in;
      end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
        rdata_d = we_q ? rdata_q : 8'hFF;
      end else cnt_d = cnt_q + 8'd1;
    endcase
    // Pins are registered, so they are decoded from the state being entered.
    drive          = (state_d == DATA) && we_d;
    pin_addr_d     = state_d == IDLE ? 8'h00 : state_d == ADDR_HI ? addr_d[15:8] : addr_d[7:0];
    pin_phase_d    = state_d;
    pin_data_oe_d  = drive ? 8'hFF : 8'h00;
    pin_data_out_d = drive ? wdata_d : 8'h00;
  end
  always_ff @(posedge clk_output) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= 16'h0000;
      we_q           <= 1'b0;
      wdata_q        <= 8'h00;
      cnt_q          <= 8'd0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      rdata_q        <= 8'h00;
      pin_addr_q     <= 8'h00;
      pin_phase_q    <= 2'd0;
      pin_data_out_q <= 8'h00;
      pin_data_oe_q  <= 8'h00;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      err_q          <= err_d;
      rdata_q        <= rdata_d;
      pin_addr_q     <= pin_addr_d;
      pin_phase_q    <= pin_phase_d;
      pin_data_out_q <= pin_data_out_d;
      pin_data_oe_q  <= pin_data_oe_d;
    end
  end
  assign bus.busy         = state_q != IDLE;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.pin_addr     = pin_addr_q;
  assign bus.pin_phase    = pin_phase_q;
  assign bus.pin_data_out = pin_data_out_q;
  assign bus.pin_data_oe  = pin_data_oe_q;
endmodule

// File: tb/tb_ext_bus_sequencer.sv
// tb_ext_bus_sequencer: directed vectors with hand-computed expectations for ext_bus_sequencer.
module tb_ext_bus_sequencer;
  logic clk_output = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  ext_bus_sequencer_if bus ();
  ext_bus_sequencer #(.MAX_WAIT(15)) dut (
    .clk_output(clk_output),
    .rst_n     (rst_n),
    .bus       (bus.slave)
  );
  always #5 clk_output = ~clk_output;
  task automatic tick;
    @(posedge clk_output);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_pins(input string tag, input logic [7:0] a, input logic [1:0] ph, input logic [7:0] oe, input logic [7:0] dout);
    chk({tag, ".pin_addr"}, 32'(bus.pin_addr), 32'(a));
    chk({tag, ".phase"}, 32'(bus.pin_phase), 32'(ph));
    chk({tag, ".oe"}, 32'(bus.pin_data_oe), 32'(oe));
    chk({tag, ".dout"}, 32'(bus.pin_data_out), 32'(dout));
  endtask
  task automatic chk_core(input string tag, input logic b, input logic d, input logic e, input logic [7:0] rd);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".done"}, 32'(bus.done), 32'(d));
    chk({tag, ".err"}, 32'(bus.err), 32'(e));
    chk({tag, ".rdata"}, 32'(bus.rdata), 32'(rd));
  endtask
  initial begin
    rst_n = 1'b0;
    bus.req = 1'b0;
    bus.addr = 16'h0000;
    bus.we = 1'b0;
    bus.wdata = 8'h00;
    bus.pin_data_in = 8'h00;
    bus.wait_n = 1'b1;
    tick;
    tick;
    chk_pins("rst", 8'h00, 2'd0, 8'h00, 8'h00);
    chk_core("rst", 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    tick;
    chk_pins("idle", 8'h00, 2'd0, 8'h00, 8'h00);
    chk_core("idle", 1'b0, 1'b0, 1'b0, 8'h00);
    bus.req = 1'b1;
    bus.addr = 16'h12A4;
    bus.we = 1'b0;
    bus.pin_data_in = 8'h5C;
    tick;
    bus.req = 1'b0;
    bus.addr = 16'h0000;
    chk_pins("rd.hi", 8'h12, 2'd1, 8'h00, 8'h00);
    chk_core("rd.hi", 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    chk_pins("rd.lo", 8'hA4, 2'd2, 8'h00, 8'h00);
    tick;
    chk_pins("rd.data", 8'hA4, 2'd3, 8'h00, 8'h00);
    chk_core("rd.data", 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    chk_core("rd.done", 1'b0, 1'b1, 1'b0, 8'h5C);
    chk_pins("rd.done", 8'h00, 2'd0, 8'h00, 8'h00);
    bus.req = 1'b1;
    bus.addr = 16'hFFFE;
    bus.we = 1'b1;
    bus.wdata = 8'h3B;
    bus.wait_n = 1'b0;
    tick;
    bus.req = 1'b0;
    bus.wdata = 8'h00;
    bus.addr = 16'h1111;
    chk_pins("wr.hi", 8'hFF, 2'd1, 8'h00, 8'h00);
    chk_core("wr.hi", 1'b1, 1'b0, 1'b0, 8'h5C);
    tick;
    chk_pins("wr.lo", 8'hFE, 2'd2, 8'h00, 8'h00);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk_pins($sformatf("wr.data%0d", i), 8'hFE, 2'd3, 8'hFF, 8'h3B);
      chk_core($sformatf("wr.data%0d", i), 1'b1, 1'b0, 1'b0, 8'h5C);
      bus.wait_n = (i == 3);
      tick;
    end
    chk_core("wr.done", 1'b0, 1'b1, 1'b0, 8'h5C);
    chk_pins("wr.done", 8'h00, 2'd0, 8'h00, 8'h00);
    bus.req = 1'b1;
    bus.addr = 16'h0042;
    bus.we = 1'b0;
    bus.wait_n = 1'b0;
    bus.pin_data_in = 8'h77;
    tick;
    bus.req = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 15; i++) begin
      chk_pins($sformatf("to.data%0d", i), 8'h42, 2'd3, 8'h00, 8'h00);
      chk_core($sformatf("to.data%0d", i), 1'b1, 1'b0, 1'b0, 8'h5C);
      tick;
    end
    chk_core("to.done", 1'b0, 1'b1, 1'b1, 8'hFF);
    chk_pins("to.done", 8'h00, 2'd0, 8'h00, 8'h00);
    bus.wait_n = 1'b1;
    tick;
    chk_core("to.after", 1'b0, 1'b0, 1'b0, 8'hFF);
    bus.req = 1'b1;
    bus.addr = 16'h3456;
    bus.we = 1'b0;
    bus.pin_data_in = 8'h99;
    tick;
    bus.addr = 16'h789A;
    chk_pins("b2b.hi1", 8'h34, 2'd1, 8'h00, 8'h00);
    tick;
    chk_pins("b2b.lo1", 8'h56, 2'd2, 8'h00, 8'h00);
    tick;
    chk_pins("b2b.data1", 8'h56, 2'd3, 8'h00, 8'h00);
    tick;
    chk_core("b2b.done1", 1'b0, 1'b1, 1'b0, 8'h99);
    chk_pins("b2b.done1", 8'h00, 2'd0, 8'h00, 8'h00);
    tick;
    chk_pins("b2b.hi2", 8'h78, 2'd1, 8'h00, 8'h00);
    chk_core("b2b.hi2", 1'b1, 1'b0, 1'b0, 8'h99);
    tick;
    chk_pins("b2b.lo2", 8'h9A, 2'd2, 8'h00, 8'h00);
    rst_n = 1'b0;
    bus.req = 1'b0;
    tick;
    chk_pins("mrst", 8'h00, 2'd0, 8'h00, 8'h00);
    chk_core("mrst", 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    tick;
    chk_pins("mrst.after", 8'h00, 2'd0, 8'h00, 8'h00);
    chk_core("mrst.after", 1'b0, 1'b0, 1'b0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
